router_ingress: RTL

Packet-ingress controller for the 1x3 router. It accepts the byte stream from the source port, decodes the destination from the header, and writes header, payload and parity into one of the three `router_fifo` instances. It drives their `write_enb` and `lfd_state`, applies backpressure to the source, and checks packet parity and length. It sits directly upstream of the three FIFOs and feeds their `data_in`.

---
 rtl/router_ingress_pkg.sv | 13 +
 rtl/router_ingress_if.sv | 24 ++
 rtl/router_ingress_buf.sv | 37 +++
 rtl/router_ingress.sv | 118 +++++++++++
 4 files changed

// File: rtl/router_ingress_pkg.sv
// router_ingress_pkg: shared widths, FSM state encoding and header field helpers for the router ingress
package router_ingress_pkg;
  localparam int WIDTH = 8;
  localparam int NPORT = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  typedef enum logic [2:0] {IDLE, WAIT_EMPTY, LOAD_DATA, CHECK, DROP} state_e;
  function automatic logic [1:0] hdr_addr(input logic [WIDTH-1:0] h);
    return h[1:0];
  endfunction
  function automatic logic [5:0] hdr_len(input logic [WIDTH-1:0] h);
    return h[7:2];
  endfunction
endpackage

// File: rtl/router_ingress_if.sv
// router_ingress_if: source handshake, FIFO write bus and packet status; master = ingress, slave = environment
interface router_ingress_if;
  import router_ingress_pkg::*;
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic [NPORT-1:0] fifo_full;
  logic [NPORT-1:0] fifo_empty;
  logic [NPORT-1:0] soft_reset;
  logic [NPORT-1:0] write_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_out;
  logic             parity_err;
  logic             len_err;
  logic             pkt_done;
  modport master (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
    output busy, write_enb, lfd_state, data_out, parity_err, len_err, pkt_done
  );
  modport slave (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
    input  busy, write_enb, lfd_state, data_out, parity_err, len_err, pkt_done
  );
endinterface

// File: rtl/router_ingress_buf.sv
// router_ingress_buf: one-entry output buffer (data, lfd, valid); load wins over drain so it reloads in place
module router_ingress_buf
  import router_ingress_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             drain,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  input  logic             lfd_in,
  output logic [WIDTH-1:0] data,
  output logic             lfd,
  output logic             vld
);
  logic [WIDTH-1:0] data_q, data_d;
  logic lfd_q, lfd_d, vld_q, vld_d;
  always_comb begin
    data_d = load ? d : data_q;
    lfd_d  = clear ? 1'b0 : load ? lfd_in : drain ? 1'b0 : lfd_q;
    vld_d  = clear ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : vld_q;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      lfd_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      lfd_q  <= lfd_d;
      vld_q  <= vld_d;
    end
  end
  assign data = data_q;
  assign lfd  = lfd_q;
  assign vld  = vld_q;
endmodule

// File: rtl/router_ingress.sv
// router_ingress: decodes packet header, streams header/payload/parity into one of three FIFOs, checks parity and length
module router_ingress
  import router_ingress_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  router_ingress_if.master bus
);
  state_e state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d, cnt_q, cnt_d;
  logic [WIDTH-1:0] par_acc_q, par_acc_d, par_rx_q, par_rx_d;
  logic perr_q, perr_d, lerr_q, lerr_d, done_q, done_d;
  logic [NPORT-1:0] port_oh, hdr_oh;
  logic full, sr, busy, fire, load, lfd_in;
  logic [WIDTH-1:0] obuf_data;
  logic obuf_lfd, obuf_vld;
  router_ingress_buf u_buf (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .drain  (fire),
    .clear  (sr),
    .d      (bus.data_in),
    .lfd_in (lfd_in),
    .data   (obuf_data),
    .lfd    (obuf_lfd),
    .vld    (obuf_vld)
  );
  assign port_oh = NPORT'(1) << addr_q;
  assign hdr_oh  = NPORT'(1) << hdr_addr(bus.data_in);
  assign full    = |(bus.fifo_full & port_oh);
  // soft reset only aborts a packet that is actually being routed to that FIFO
  assign sr      = |(bus.soft_reset & port_oh) & (state_q inside {WAIT_EMPTY, LOAD_DATA, CHECK});
  assign busy    = (state_q == LOAD_DATA) ? (obuf_vld & full) : (state_q inside {WAIT_EMPTY, CHECK});
  // the header may not leave the buffer until its FIFO has been seen empty
  assign fire    = obuf_vld & ~full & (state_q != WAIT_EMPTY) & ~sr;
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    par_acc_d = par_acc_q;
    par_rx_d  = par_rx_q;
    perr_d    = perr_q;
    lerr_d    = lerr_q;
    done_d    = 1'b0;
    load      = 1'b0;
    lfd_in    = 1'b0;
    if (sr) state_d = bus.pkt_valid ? DROP : IDLE;
    else begin
      case (state_q)
        IDLE: if (bus.pkt_valid) begin
          if (hdr_addr(bus.data_in) == ADDR_INVALID) state_d = DROP;
          else begin
            load      = 1'b1;
            lfd_in    = 1'b1;
            addr_d    = hdr_addr(bus.data_in);
            len_d     = hdr_len(bus.data_in);
            par_acc_d = bus.data_in;
            cnt_d     = '0;
            state_d   = |(bus.fifo_empty & hdr_oh) ? LOAD_DATA : WAIT_EMPTY;
          end
        end
        WAIT_EMPTY: state_d = |(bus.fifo_empty & port_oh) ? LOAD_DATA : WAIT_EMPTY;
        LOAD_DATA: if (!busy) begin
          load = 1'b1;
          if (bus.pkt_valid) begin
            par_acc_d = par_acc_q ^ bus.data_in;
            cnt_d     = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;
          end else begin
            par_rx_d = bus.data_in;
            state_d  = CHECK;
          end
        end
        // the status is launched on the edge that writes the parity byte
        CHECK: if (!obuf_vld || fire) begin
          done_d  = 1'b1;
          perr_d  = par_acc_q != par_rx_q;
          lerr_d  = cnt_q != len_q;
          state_d = IDLE;
        end
        DROP: state_d = bus.pkt_valid ? DROP : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      par_acc_q <= '0;
      par_rx_q  <= '0;
      perr_q    <= 1'b0;
      lerr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      par_acc_q <= par_acc_d;
      par_rx_q  <= par_rx_d;
      perr_q    <= perr_d;
      lerr_q    <= lerr_d;
      done_q    <= done_d;
    end
  end
  assign bus.busy       = busy;
  assign bus.write_enb  = fire ? port_oh : '0;
  assign bus.data_out   = obuf_data;
  assign bus.lfd_state  = obuf_lfd & fire;
  assign bus.parity_err = perr_q;
  assign bus.len_err    = lerr_q;
  assign bus.pkt_done   = done_q;
endmodule
